// File: rtl/volume_scaler.sv
// Stereo volume stage: sign-magnitude gain multiply with per-sample gain ramping
// and a soft-mute FSM; three-cycle pipeline from Strobe to Out_Valid.
module volume_scaler #(
    parameter int AUDIO_W = 16,
    parameter int GAIN_W  = 16,
    parameter int STEP    = 64
) (
    input  logic                       Clk,
    input  logic                       nReset,
    input  logic                       Strobe,
    input  logic [AUDIO_W-1:0]         Audio_L,
    input  logic [AUDIO_W-1:0]         Audio_R,
    input  logic [GAIN_W-1:0]          Gain_L,
    input  logic [GAIN_W-1:0]          Gain_R,
    input  logic                       Mute,
    output logic [AUDIO_W+GAIN_W-1:0]  Out_L,
    output logic [AUDIO_W+GAIN_W-1:0]  Out_R,
    output logic                       Out_Valid,
    output logic                       Muted,
    output logic [1:0]                 Dbg_State
);
    localparam int OUT_W = AUDIO_W + GAIN_W;
    localparam logic [GAIN_W-1:0] STEP_G = GAIN_W'(STEP);

    typedef enum logic [1:0] {
        UNMUTED   = 2'd0,
        RAMP_DOWN = 2'd1,
        MUTED     = 2'd2,
        RAMP_UP   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [GAIN_W-1:0] g_l, g_r, g_l_nxt, g_r_nxt, t_l, t_r;

    // One ramp step toward t, landing exactly on t when within STEP.
    function automatic logic [GAIN_W-1:0] ramp(input logic [GAIN_W-1:0] g,
                                               input logic [GAIN_W-1:0] t);
        if (t >= g) ramp = ((t - g) <= STEP_G) ? t : g + STEP_G;
        else        ramp = ((g - t) <= STEP_G) ? t : g - STEP_G;
    endfunction

    always_comb begin
        state_nxt = state;
        t_l       = Mute ? '0 : Gain_L;
        t_r       = Mute ? '0 : Gain_R;
        g_l_nxt   = ramp(g_l, t_l);
        g_r_nxt   = ramp(g_r, t_r);
        case (state)
            UNMUTED:   if (Mute) state_nxt = RAMP_DOWN;
            RAMP_DOWN: begin
                if (!Mute)                                state_nxt = RAMP_UP;
                else if (g_l_nxt == '0 && g_r_nxt == '0)  state_nxt = MUTED;
            end
            MUTED:     if (!Mute) state_nxt = RAMP_UP;
            RAMP_UP: begin
                if (Mute)                                          state_nxt = RAMP_DOWN;
                else if (g_l_nxt == Gain_L && g_r_nxt == Gain_R)   state_nxt = UNMUTED;
            end
            default:   state_nxt = MUTED;
        endcase
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state <= MUTED;
            g_l   <= '0;
            g_r   <= '0;
        end else if (Strobe) begin
            state <= state_nxt;
            g_l   <= g_l_nxt;
            g_r   <= g_r_nxt;
        end
    end

    assign Muted     = (state == MUTED);
    assign Dbg_State = state;

    logic                s1_valid, s1_sign_l, s1_sign_r;
    logic [AUDIO_W-1:0]  s1_abs_l, s1_abs_r;
    logic [GAIN_W-1:0]   s1_g_l, s1_g_r;
    logic                s2_valid, s2_sign_l, s2_sign_r;
    logic [OUT_W-1:0]    s2_prod_l, s2_prod_r;

    // Magnitude fits unsigned AUDIO_W bits even for the most negative sample.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            s1_valid  <= 1'b0;
            s1_sign_l <= 1'b0;
            s1_sign_r <= 1'b0;
            s1_abs_l  <= '0;
            s1_abs_r  <= '0;
            s1_g_l    <= '0;
            s1_g_r    <= '0;
            s2_valid  <= 1'b0;
            s2_sign_l <= 1'b0;
            s2_sign_r <= 1'b0;
            s2_prod_l <= '0;
            s2_prod_r <= '0;
            Out_L     <= '0;
            Out_R     <= '0;
            Out_Valid <= 1'b0;
        end else begin
            s1_valid  <= Strobe;
            if (Strobe) begin
                s1_sign_l <= Audio_L[AUDIO_W-1];
                s1_sign_r <= Audio_R[AUDIO_W-1];
                s1_abs_l  <= Audio_L[AUDIO_W-1] ? -Audio_L : Audio_L;
                s1_abs_r  <= Audio_R[AUDIO_W-1] ? -Audio_R : Audio_R;
                s1_g_l    <= g_l;
                s1_g_r    <= g_r;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_sign_l <= s1_sign_l;
                s2_sign_r <= s1_sign_r;
                s2_prod_l <= OUT_W'(s1_abs_l) * OUT_W'(s1_g_l);
                s2_prod_r <= OUT_W'(s1_abs_r) * OUT_W'(s1_g_r);
            end
            Out_Valid <= s2_valid;
            if (s2_valid) begin
                Out_L <= s2_sign_l ? -s2_prod_l : s2_prod_l;
                Out_R <= s2_sign_r ? -s2_prod_r : s2_prod_r;
            end
        end
    end
endmodule

// File: tb/tb_volume_scaler.sv
// Bench for volume_scaler: directed corner sequences, a full-gain vector table,
// and randomized strobes scored against a gain/mute reference model.
module tb_volume_scaler;
    localparam int STEP = 64;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        strobe = 1'b0;
    logic [15:0] audio_l = '0, audio_r = '0;
    logic [15:0] gain_l = '0, gain_r = '0;
    logic        mute = 1'b0;
    logic [31:0] out_l, out_r;
    logic        out_valid, muted;
    logic [1:0]  dbg_state;

    volume_scaler #(.AUDIO_W(16), .GAIN_W(16), .STEP(STEP)) dut (
        .Clk(clk), .nReset(n_reset), .Strobe(strobe),
        .Audio_L(audio_l), .Audio_R(audio_r), .Gain_L(gain_l), .Gain_R(gain_r),
        .Mute(mute), .Out_L(out_l), .Out_R(out_r), .Out_Valid(out_valid),
        .Muted(muted), .Dbg_State(dbg_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Scoreboard: {expected cycle, expected left, expected right}.
    logic [95:0] exp_q[$];
    int          obs_q[$];

    typedef enum {M_UNMUTED, M_DOWN, M_MUTED, M_UP} mstate_t;
    mstate_t m_st;
    int      m_gl, m_gr;
    bit      m_muted;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int clamp_step(input int d);
        if (d > STEP) return STEP;
        if (d < -STEP) return -STEP;
        return d;
    endfunction

    task automatic model_reset();
        m_gl = 0; m_gr = 0; m_st = M_MUTED; m_muted = 1'b1;
        exp_q.delete();
    endtask

    task automatic model_accept(input int al, input int ar, input int gl, input int gr, input bit mt);
        longint pl, pr;
        int tl, tr;
        pl = longint'(al) * longint'(m_gl);
        pr = longint'(ar) * longint'(m_gr);
        exp_q.push_back({32'(cyc + 3), pl[31:0], pr[31:0]});
        tl = mt ? 0 : gl;
        tr = mt ? 0 : gr;
        m_gl = m_gl + clamp_step(tl - m_gl);
        m_gr = m_gr + clamp_step(tr - m_gr);
        case (m_st)
            M_UNMUTED: if (mt) m_st = M_DOWN;
            M_DOWN:    if (!mt) m_st = M_UP; else if (m_gl == 0 && m_gr == 0) m_st = M_MUTED;
            M_MUTED:   if (!mt) m_st = M_UP;
            M_UP:      if (mt) m_st = M_DOWN; else if (m_gl == gl && m_gr == gr) m_st = M_UNMUTED;
        endcase
        m_muted = (m_st == M_MUTED);
    endtask

    task automatic monitor();
        logic [95:0] e;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("valid_cycle", cyc, longint'(e[95:64]));
                check("out_l", $signed(out_l), $signed(e[63:32]));
                check("out_r", $signed(out_r), $signed(e[31:0]));
            end
            obs_q.push_back($signed(out_l));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        monitor();
    endtask

    task automatic idle(input int n);
        strobe = 1'b0;
        repeat (n) cycle();
    endtask

    // Leaves strobe high so back-to-back calls give consecutive strobes.
    task automatic do_strobe(input int al, input int ar, input int gl, input int gr, input bit mt);
        audio_l = 16'(al); audio_r = 16'(ar);
        gain_l = 16'(gl); gain_r = 16'(gr);
        mute = mt; strobe = 1'b1;
        model_accept(al, ar, gl, gr, mt);
        cycle();
        check("muted", muted, m_muted);
    endtask

    task automatic check_obs(input string name, input int exp);
        if (obs_q.size() == 0) check({name, "_missing"}, 0, 1);
        else check(name, obs_q.pop_front(), exp);
    endtask

    typedef struct {
        int     al;
        int     ar;
        longint el;
        longint er;
    } vec_t;
    vec_t tbl[6];

    initial begin
        logic [15:0] r16;
        int ra, rb, rgl, rgr;
        bit rmute;

        tbl[0] = '{al: -32768, ar: 32767,  el: -2147450880, er: 2147385345};
        tbl[1] = '{al: 0,      ar: 0,      el: 0,           er: 0};
        tbl[2] = '{al: 1,      ar: -1,     el: 65535,       er: -65535};
        tbl[3] = '{al: 100,    ar: -100,   el: 6553500,     er: -6553500};
        tbl[4] = '{al: 16384,  ar: -16384, el: 1073725440,  er: -1073725440};
        tbl[5] = '{al: -1,     ar: 1,      el: -65535,      er: 65535};

        model_reset();
        idle(3);
        check("reset_valid", out_valid, 0);
        check("reset_out_l", out_l, 0);
        check("reset_muted", muted, 1);
        n_reset = 1'b1;
        idle(2);

        // Unmute ramp from reset: used gains 0,64..960 then 1000.
        obs_q.delete();
        for (int i = 0; i < 20; i++) begin
            do_strobe(1, 1, 1000, 1000, 0);
            if (i == 0) check("t1_muted_drop", muted, 0);
        end
        idle(4);
        for (int i = 0; i < 20; i++) check_obs("t1_gain", (i < 16) ? i * 64 : 1000);

        // Settle at 200, then soft mute: 200,136,72,8 then 0.
        for (int i = 0; i < 100 && !(m_gl == 200 && m_st == M_UNMUTED); i++) do_strobe(1, 1, 200, 200, 0);
        idle(4);
        obs_q.delete();
        for (int i = 0; i < 4; i++) begin
            do_strobe(1, 1, 200, 200, 1);
            check("t3_muted", muted, (i == 3) ? 1 : 0);
        end
        do_strobe(12345, -7, 200, 200, 1);
        idle(4);
        check_obs("t3_g", 200); check_obs("t3_g", 136); check_obs("t3_g", 72);
        check_obs("t3_g", 8);   check_obs("t3_g", 0);
        check("t3_out_r_zero", out_r, 0);

        // Reverse a ramp-down at 72.
        for (int i = 0; i < 4; i++) do_strobe(1, 1, 200, 200, 0);
        do_strobe(1, 1, 200, 200, 1);
        do_strobe(1, 1, 200, 200, 1);
        idle(4);
        obs_q.delete();
        for (int i = 0; i < 3; i++) do_strobe(1, 1, 200, 200, 0);
        idle(4);
        check_obs("t4_g", 72); check_obs("t4_g", 136); check_obs("t4_g", 200);
        check("t4_muted", muted, 0);

        // Three back-to-back strobes at gain 200.
        obs_q.delete();
        do_strobe(100, 1, 200, 200, 0);
        do_strobe(-200, 2, 200, 200, 0);
        do_strobe(300, 3, 200, 200, 0);
        idle(4);
        check_obs("t5_order", 20000); check_obs("t5_order", -40000); check_obs("t5_order", 60000);

        // Full-gain vector table.
        for (int i = 0; i < 1100 && m_gl != 65535; i++) do_strobe(0, 0, 65535, 65535, 0);
        check("t2_model_full_gain", m_gl, 65535);
        do_strobe(0, 0, 65535, 65535, 0);
        idle(4);
        foreach (tbl[i]) begin
            do_strobe(tbl[i].al, tbl[i].ar, 65535, 65535, 0);
            idle(2);
            check("tbl_valid", out_valid, 1);
            check("tbl_out_l", $signed(out_l), tbl[i].el);
            check("tbl_out_r", $signed(out_r), tbl[i].er);
        end
        idle(2);

        // Reset one cycle after a strobe: sample dropped, outputs cleared at once.
        do_strobe(1234, -1234, 65535, 65535, 0);
        strobe = 1'b0;
        n_reset = 1'b0;
        #1;
        check("t6_valid", out_valid, 0);
        check("t6_out_l", out_l, 0);
        check("t6_out_r", out_r, 0);
        check("t6_muted", muted, 1);
        model_reset();
        idle(2);
        n_reset = 1'b1;
        idle(5);
        check("t6_out_l_after", out_l, 0);

        // Randomized traffic with gaps, gain changes and mute toggles.
        rgl = 3000; rgr = 500; rmute = 1'b0;
        for (int i = 0; i < 400; i++) begin
            r16 = 16'($urandom); ra = int'($signed(r16));
            r16 = 16'($urandom); rb = int'($signed(r16));
            if ($urandom_range(0, 15) == 0) rgl = $urandom_range(0, 65535);
            if ($urandom_range(0, 15) == 0) rgr = $urandom_range(0, 4000);
            if ($urandom_range(0, 19) == 0) rmute = ~rmute;
            do_strobe(ra, rb, rgl, rgr, rmute);
            idle($urandom_range(0, 2));
        end
        idle(5);
        check("queue_drained", exp_q.size(), 0);

        $display("final fsm state code %0d", dbg_state);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
